pulse_sync_mc: RTL and testbench



---
 rtl/pulse_sync_mc.sv | 106 ++++++++++
 tb/tb_pulse_sync_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_mc.sv
// pulse_sync_mc: multi-channel toggle-handshake pulse synchronizer, clock_a -> clock_b.
// Each channel queues source events in a saturating counter and launches them one at
// a time over a req/ack toggle handshake, so bursts are delivered rather than merged.
`timescale 1ns/1ps
module pulse_sync_mc #(
  parameter int CHANNELS    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                clock_a,
  input  logic                clock_b,
  input  logic                async_rst_n,
  input  logic [CHANNELS-1:0] pls_a,
  input  logic [CHANNELS-1:0] clr_ovf_a,
  output logic [CHANNELS-1:0] pls_b,
  output logic [CHANNELS-1:0] busy_a,
  output logic [CHANNELS-1:0] pending_a,
  output logic [CHANNELS-1:0] overflow_a,
  output logic                idle_a
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // clock_a side state
    logic [CNT_W-1:0]       pend_cnt_r;
    logic                   req_tgl_r;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   ovf_r;
    // clock_b side state
    logic [SYNC_STAGES-1:0] req_sync_r;
    logic                   d_r;
    // clock_a side decode
    logic                   busy_s;
    logic                   has_pend_s;
    logic                   launch_s;
    logic                   inc_s;
    logic                   dec_s;
    logic                   drop_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    // Launch decision and pending-counter next state; a pulse that launches
    // directly from an empty queue is consumed and never counted.
    always_comb begin
      busy_s     = req_tgl_r ^ ack_sync_r[SYNC_STAGES-1];
      has_pend_s = (pend_cnt_r != CNT_ZERO);
      launch_s   = !busy_s && (has_pend_s || pls_a[c]);
      dec_s      = launch_s && has_pend_s;
      inc_s      = pls_a[c] && (has_pend_s || busy_s);
      drop_s     = inc_s && !dec_s && (pend_cnt_r == CNT_MAX);
      cnt_nxt_s  = pend_cnt_r;
      case ({inc_s, dec_s})
        2'b10: begin
          if (drop_s) begin
            cnt_nxt_s = pend_cnt_r;
          end else begin
            cnt_nxt_s = pend_cnt_r + CNT_ONE;
          end
        end
        2'b01:   cnt_nxt_s = pend_cnt_r - CNT_ONE;
        default: cnt_nxt_s = pend_cnt_r;
      endcase
    end

    // clock_a registers: counter, request toggle, ack synchronizer, sticky overflow
    always_ff @(posedge clock_a or negedge async_rst_n) begin
      if (!async_rst_n) begin
        pend_cnt_r <= CNT_ZERO;
        req_tgl_r  <= 1'b0;
        ack_sync_r <= {SYNC_STAGES{1'b0}};
        ovf_r      <= 1'b0;
      end else begin
        pend_cnt_r <= cnt_nxt_s;
        req_tgl_r  <= req_tgl_r ^ launch_s;
        ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], d_r};
        if (drop_s) begin
          ovf_r <= 1'b1;
        end else if (clr_ovf_a[c]) begin
          ovf_r <= 1'b0;
        end
      end
    end

    // clock_b registers: request synchronizer and delay flop (delay flop doubles as ack toggle)
    always_ff @(posedge clock_b or negedge async_rst_n) begin
      if (!async_rst_n) begin
        req_sync_r <= {SYNC_STAGES{1'b0}};
        d_r        <= 1'b0;
      end else begin
        req_sync_r <= {req_sync_r[SYNC_STAGES-2:0], req_tgl_r};
        d_r        <= req_sync_r[SYNC_STAGES-1];
      end
    end

    // Outputs are XOR/compare decodes of flops of a single domain, so glitch-free
    assign pls_b[c]      = req_sync_r[SYNC_STAGES-1] ^ d_r;
    assign busy_a[c]     = busy_s;
    assign pending_a[c]  = has_pend_s;
    assign overflow_a[c] = ovf_r;
  end

  assign idle_a = ~((|busy_a) | (|pending_a));

endmodule

// File: tb/tb_pulse_sync_mc.sv
// Scoreboard bench for pulse_sync_mc: each accepted source event pushes a token into a
// per-channel queue; a clock_b monitor pops one token per delivered pls_b pulse.
`timescale 1ns/1ps
module tb_pulse_sync_mc;
  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int CW  = 2;
  localparam int CAP = 1 << CW;   // one in flight plus 2^CW-1 queued

  logic          clock_a = 1'b0;
  logic          clock_b = 1'b0;
  logic          async_rst_n = 1'b0;
  logic [CH-1:0] pls_a = '0;
  logic [CH-1:0] clr_ovf_a = '0;
  logic [CH-1:0] pls_b, busy_a, pending_a, overflow_a;
  logic          idle_a;

  pulse_sync_mc #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clock_a(clock_a), .clock_b(clock_b), .async_rst_n(async_rst_n),
    .pls_a(pls_a), .clr_ovf_a(clr_ovf_a), .pls_b(pls_b), .busy_a(busy_a),
    .pending_a(pending_a), .overflow_a(overflow_a), .idle_a(idle_a));

  real hb = 20.3;   // clock_b half period, changed between phases
  always #5 clock_a = ~clock_a;
  initial begin
    #1;
    forever #(hb) clock_b = ~clock_b;
  end

  int            n_vec = 0;
  int            n_err = 0;
  int            exp_q [CH][$];
  int            win_id = 0;
  int            pulses_b = 0;
  logic [CH-1:0] ovf_m = '0;
  int            n_ev [CH];
  logic [CH-1:0] win_pls [8];
  logic [CH-1:0] win_clr [8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pulse width, inter-pulse gap and scoreboard pop per delivered pulse
  logic [CH-1:0] prev_b = '0;
  int high_run [CH] = '{default: 0};
  int low_run  [CH] = '{default: 100};
  always @(negedge clock_b) begin
    for (int c = 0; c < CH; c++) begin
      if (pls_b[c] === 1'b1) begin
        high_run[c]++;
        if (!prev_b[c]) begin
          pulses_b++;
          check($sformatf("pls_b_gap ch%0d", c), (low_run[c] >= SS) ? 1 : 0, 1);
          low_run[c] = 0;
          check($sformatf("sb_nonempty ch%0d", c), (exp_q[c].size() > 0) ? 1 : 0, 1);
          if (exp_q[c].size() > 0) begin
            int tok;
            tok = exp_q[c].pop_front();
            check($sformatf("sb_token ch%0d", c), tok, win_id);
          end
        end
      end else begin
        if (prev_b[c]) begin
          check($sformatf("pls_b_width ch%0d", c), high_run[c], 1);
        end
        high_run[c] = 0;
        low_run[c]++;
      end
    end
    prev_b = pls_b;
  end

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int c = 0; c < CH; c++) if (exp_q[c].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " pls_b"}, pls_b, 0);
    check({tag, " busy_a"}, busy_a, 0);
    check({tag, " pending_a"}, pending_a, 0);
    check({tag, " overflow_a"}, overflow_a, 0);
    check({tag, " idle_a"}, idle_a, 1);
  endtask

  // Wait for every channel to go quiet and all expected pulses to arrive, then check
  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clock_a); #1;
      if (idle_a === 1'b1 && all_empty()) done = 1'b1;
    end
    check("drain_timeout", done, 1);
    check("idle_a after drain", idle_a, 1);
    check("busy_a after drain", busy_a, 0);
    check("pending_a after drain", pending_a, 0);
    check("overflow_a after drain", overflow_a, ovf_m);
  endtask

  // Apply win_pls/win_clr for len cycles starting from idle; model acceptance by capacity
  task automatic run_window(input int len, input bit slow);
    win_id++;
    for (int c = 0; c < CH; c++) n_ev[c] = 0;
    for (int i = 0; i < len; i++) begin
      pls_a     = win_pls[i];
      clr_ovf_a = win_clr[i];
      for (int c = 0; c < CH; c++) begin
        bit drop = 1'b0;
        if (win_pls[i][c]) begin
          if (n_ev[c] < CAP) exp_q[c].push_back(win_id);
          else drop = 1'b1;
          n_ev[c]++;
        end
        if (drop) ovf_m[c] = 1'b1;
        else if (win_clr[i][c]) ovf_m[c] = 1'b0;
      end
      @(posedge clock_a); #1;
    end
    pls_a = '0;
    clr_ovf_a = '0;
    if (slow) begin
      // first handshake is still in flight, so queue state is fully determined
      for (int c = 0; c < CH; c++) begin
        check($sformatf("win busy_a ch%0d", c), busy_a[c], (n_ev[c] > 0) ? 1 : 0);
        check($sformatf("win pending_a ch%0d", c), pending_a[c], (n_ev[c] > 1) ? 1 : 0);
      end
      check("win overflow_a", overflow_a, ovf_m);
    end
    drain();
  endtask

  task automatic clear_win();
    for (int i = 0; i < 8; i++) begin
      win_pls[i] = '0;
      win_clr[i] = '0;
    end
  endtask

  initial begin
    int p0;
    #20;
    check_reset_vals("reset");
    @(posedge clock_a); #2;
    async_rst_n = 1'b1;
    repeat (4) @(posedge clock_a);
    #1;
    check_reset_vals("post-release");

    // ---- slow clock_b (about 4x slower than clock_a): directed cases ----
    clear_win();
    win_pls[0] = 4'b1010; win_pls[1] = 4'b0101;
    run_window(2, 1'b1);

    clear_win();   // single event
    win_pls[0] = 4'b0001;
    run_window(1, 1'b1);

    clear_win();   // burst of 6 on ch0: 1 in flight + 3 queued, 2 dropped
    for (int i = 0; i < 6; i++) win_pls[i] = 4'b0001;
    run_window(6, 1'b1);

    clear_win();   // clear the sticky flag
    win_clr[0] = 4'b0001;
    run_window(1, 1'b1);

    clear_win();   // clear coincident with a drop: set wins
    for (int i = 0; i < 5; i++) win_pls[i] = 4'b0001;
    win_clr[4] = 4'b0001;
    run_window(5, 1'b1);

    clear_win();   // burst of 5 on ch2 then clear in a separate window
    for (int i = 0; i < 5; i++) win_pls[i] = 4'b0100;
    run_window(5, 1'b1);
    clear_win();
    win_clr[0] = 4'b0101;
    run_window(1, 1'b1);

    // ---- reset mid-handshake with pend_cnt at max ----
    win_id++;
    for (int i = 0; i < 5; i++) begin
      pls_a = 4'b0001;
      if (i < CAP) exp_q[0].push_back(win_id);
      @(posedge clock_a); #1;
    end
    pls_a = '0;
    check("pre-reset busy_a[0]", busy_a[0], 1);
    check("pre-reset pending_a[0]", pending_a[0], 1);
    async_rst_n = 1'b0;
    #1;
    check_reset_vals("mid-op reset");
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    ovf_m = '0;
    repeat (3) @(posedge clock_a);
    #2;
    async_rst_n = 1'b1;
    p0 = pulses_b;
    repeat (20) @(posedge clock_b);
    #1;
    check("no pls_b after reset", pulses_b, p0);
    check_reset_vals("after reset release");

    // ---- slow clock_b: random windows up to 8 cycles ----
    for (int w = 0; w < 120; w++) begin
      int len;
      clear_win();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        win_pls[i] = CH'($urandom);
        win_clr[i] = CH'($urandom & $urandom & $urandom);
      end
      run_window(len, 1'b1);
    end

    // ---- fast clock_b (about 4x faster): random windows up to 4 cycles ----
    hb = 1.3;
    repeat (10) @(posedge clock_a);
    for (int w = 0; w < 300; w++) begin
      int len;
      clear_win();
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        win_pls[i] = CH'($urandom);
        win_clr[i] = CH'($urandom & $urandom);
      end
      run_window(len, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
